// File: rtl/led_symbol_shifter.sv
// LED window shift register: serial bits enter at led[0], drop removes the newest GROUP-bit symbol.
// One-cycle latency on led/count/overflow/match_pulse; no backpressure, every command is accepted.
module led_symbol_shifter #(
    parameter int unsigned        WIDTH   = 18,
    parameter int unsigned        GROUP   = 4,
    parameter int unsigned        PAT_LEN = 8,
    parameter logic [PAT_LEN-1:0] PATTERN = 8'hA5,
    localparam int unsigned       CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             drop_req,
    output logic [WIDTH-1:0] led,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             match,
    output logic             match_pulse
);

    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] GROUP_C = CW'(GROUP);
    localparam logic [CW-1:0] PAT_C   = CW'(PAT_LEN);

    logic [WIDTH-1:0] led_next;
    logic [CW-1:0]    count_next;
    logic             overflow_next;
    logic             match_next;

    always_comb begin
        led_next      = led;
        count_next    = count;
        overflow_next = overflow;
        if (clear) begin
            led_next      = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else if (drop_req) begin
            // Bits above count are always zero, so a drop on a short window just empties it.
            led_next   = led >> GROUP;
            count_next = (count >= GROUP_C) ? count - GROUP_C : '0;
        end else if (in_valid) begin
            led_next = {led[WIDTH-2:0], in_bit};
            if (count == WIDTH_C) begin
                overflow_next = 1'b1;
            end else begin
                count_next = count + CW'(1);
            end
        end
    end

    assign match_next = (count_next >= PAT_C) && (led_next[PAT_LEN-1:0] == PATTERN);
    assign match      = (count >= PAT_C) && (led[PAT_LEN-1:0] == PATTERN);
    assign empty      = (count == '0);
    assign full       = (count == WIDTH_C);

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            led         <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            match_pulse <= 1'b0;
        end else begin
            led         <= led_next;
            count       <= count_next;
            overflow    <= overflow_next;
            match_pulse <= match_next & ~match;
        end
    end

endmodule

// File: tb/tb_led_symbol_shifter.sv
// Testbench for led_symbol_shifter: directed scenarios then random traffic against a bit-queue model.
module tb_led_symbol_shifter;

    localparam int WIDTH   = 18;
    localparam int GROUP   = 4;
    localparam int PAT_LEN = 8;
    localparam int CW      = 5;
    localparam logic [7:0] PATTERN = 8'hA5;

    logic             clk1 = 1'b0;
    logic             reset;
    logic             clear;
    logic             in_valid;
    logic             in_bit;
    logic             drop_req;
    logic [WIDTH-1:0] led;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             match;
    logic             match_pulse;

    led_symbol_shifter #(
        .WIDTH  (WIDTH),
        .GROUP  (GROUP),
        .PAT_LEN(PAT_LEN),
        .PATTERN(PATTERN)
    ) dut (
        .clk1       (clk1),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .drop_req   (drop_req),
        .led        (led),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .match      (match),
        .match_pulse(match_pulse)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queue of valid data bits, oldest at front, newest at back.
    bit q[$];
    bit m_ovf;
    bit m_pulse;

    function automatic logic [WIDTH-1:0] m_led();
        logic [WIDTH-1:0] v = '0;
        for (int i = 0; i < q.size(); i++) v[i] = q[q.size() - 1 - i];
        return v;
    endfunction

    function automatic bit m_match();
        if (q.size() < PAT_LEN) return 1'b0;
        for (int i = 0; i < PAT_LEN; i++)
            if (q[q.size() - 1 - i] != PATTERN[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".led"},         32'(led),         32'(m_led()));
        chk({tag, ".count"},       32'(count),       32'(q.size()));
        chk({tag, ".empty"},       32'(empty),       32'(q.size() == 0));
        chk({tag, ".full"},        32'(full),        32'(q.size() == WIDTH));
        chk({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
        chk({tag, ".match"},       32'(match),       32'(m_match()));
        chk({tag, ".match_pulse"}, 32'(match_pulse), 32'(m_pulse));
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_pulse = 1'b0;
    endtask

    // Drive one cycle of commands, advance the model, then compare after the edge.
    task automatic step(input string tag, input bit c, input bit d, input bit v, input bit b);
        bit prev;
        clear    = c;
        drop_req = d;
        in_valid = v;
        in_bit   = b;
        @(posedge clk1);
        #1;
        prev = m_match();
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (d) begin
            for (int i = 0; i < GROUP; i++) if (q.size() > 0) void'(q.pop_back());
        end else if (v) begin
            q.push_back(b);
            if (q.size() > WIDTH) begin
                void'(q.pop_front());
                m_ovf = 1'b1;
            end
        end
        m_pulse = m_match() && !prev;
        check_all(tag);
        clear    = 1'b0;
        drop_req = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        drop_req = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk1);
        reset = 1'b0;

        // Fill to full with ones, then one more push overflows.
        for (int i = 0; i < WIDTH; i++) step("fill", 0, 0, 1, 1);
        chk("t1_led", 32'(led), 32'h3FFFF);
        chk("t1_full", 32'(full), 32'd1);
        step("ovf", 0, 0, 1, 0);
        chk("t2_led", 32'(led), 32'h3FFFE);
        chk("t2_ovf", 32'(overflow), 32'd1);
        step("drop_keeps_ovf", 0, 1, 0, 0);
        step("hold", 0, 0, 0, 0);
        step("clear", 1, 0, 1, 1);
        chk("t2_empty", 32'(empty), 32'd1);

        // Backspace: 1,0,1,1,0 then two drops.
        step("t3_s0", 0, 0, 1, 1);
        step("t3_s1", 0, 0, 1, 0);
        step("t3_s2", 0, 0, 1, 1);
        step("t3_s3", 0, 0, 1, 1);
        step("t3_s4", 0, 0, 1, 0);
        step("t3_drop1", 0, 1, 0, 0);
        chk("t3_led1", 32'(led), 32'h1);
        step("t3_drop2", 0, 1, 0, 0);
        chk("t3_count2", 32'(count), 32'd0);
        step("t3_drop_empty", 0, 1, 0, 0);

        // Drop wins over a simultaneous shift.
        for (int i = 0; i < 6; i++) step("t4_fill", 0, 0, 1, 1);
        step("t4_drop_valid", 0, 1, 1, 1);
        chk("t4_count", 32'(count), 32'd2);
        chk("t4_led", 32'(led), 32'h3);
        step("t4_clear", 1, 0, 0, 0);

        // Pattern match and pulse.
        for (int i = PAT_LEN - 1; i >= 0; i--) step("t5_shift", 0, 0, 1, PATTERN[i]);
        chk("t5_match", 32'(match), 32'd1);
        chk("t5_pulse", 32'(match_pulse), 32'd1);
        step("t5_idle", 0, 0, 0, 0);
        chk("t5_pulse_low", 32'(match_pulse), 32'd0);
        step("t5_break", 0, 0, 1, 0);
        chk("t5_match_low", 32'(match), 32'd0);

        // Asynchronous reset between edges.
        step("t6_s0", 0, 0, 1, 1);
        step("t6_s1", 0, 0, 1, 1);
        @(posedge clk1);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6_async");
        @(negedge clk1);
        reset = 1'b0;
        step("t6_after", 0, 0, 1, 1);
        chk("t6_led", 32'(led), 32'h1);
        chk("t6_count", 32'(count), 32'd1);

        // Random traffic; occasionally inject the pattern to exercise match edges.
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step("rnd_clear", 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            end else if (r < 15) begin
                step("rnd_drop", 0, 1, $urandom_range(0, 1), $urandom_range(0, 1));
            end else if (r < 20) begin
                for (int i = PAT_LEN - 1; i >= 0; i--) step("rnd_pat", 0, 0, 1, PATTERN[i]);
            end else if (r < 80) begin
                step("rnd_shift", 0, 0, 1, $urandom_range(0, 1));
            end else begin
                step("rnd_hold", 0, 0, 0, $urandom_range(0, 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
